// File: rtl/ct_l2cache_dirty_pkg.sv
// Shared constants and state encoding for the L2 dirty-array access controller.
// The array holds 16 ways of a 9-bit state field per index, 144 bits per row.
package ct_l2cache_dirty_pkg;

    localparam int L2C_TAG_INDEX_WIDTH = 9;
    localparam int L2C_DIRTY_WAYS      = 16;
    localparam int L2C_DIRTY_WAY_BITS  = 9;
    localparam int L2C_DIRTY_WIDTH     = L2C_DIRTY_WAYS * L2C_DIRTY_WAY_BITS;

    typedef enum logic {
        L2C_DIRTY_INIT = 1'b0,
        L2C_DIRTY_IDLE = 1'b1
    } l2c_dirty_state_e;

endpackage

// File: rtl/ct_l2cache_dirty_ctrl_if.sv
// Request/response handshake plus the point-to-point dirty-array wiring.
// The controller takes the slave view; the requester/array side takes the master view.
interface ct_l2cache_dirty_ctrl_if
    import ct_l2cache_dirty_pkg::*;
#(
    parameter int TAG_INDEX_WIDTH = L2C_TAG_INDEX_WIDTH
);

    logic                         req_vld;
    logic                         req_rdy;
    logic                         req_wr;
    logic [TAG_INDEX_WIDTH-1:0]   req_idx;
    logic [3:0]                   req_way;
    logic [L2C_DIRTY_WAY_BITS-1:0] req_data;

    logic                         init_req;
    logic                         init_busy;

    logic                         rsp_vld;
    logic [L2C_DIRTY_WIDTH-1:0]   rsp_data;

    logic                         dirty_cen;
    logic                         dirty_gwen;
    logic [TAG_INDEX_WIDTH-1:0]   dirty_idx;
    logic [L2C_DIRTY_WIDTH-1:0]   dirty_din;
    logic [L2C_DIRTY_WIDTH-1:0]   dirty_wen;
    logic [L2C_DIRTY_WIDTH-1:0]   dirty_dout;

    modport master (
        output req_vld, req_wr, req_idx, req_way, req_data, init_req, dirty_dout,
        input  req_rdy, init_busy, rsp_vld, rsp_data,
        input  dirty_cen, dirty_gwen, dirty_idx, dirty_din, dirty_wen
    );

    modport slave (
        input  req_vld, req_wr, req_idx, req_way, req_data, init_req, dirty_dout,
        output req_rdy, init_busy, rsp_vld, rsp_data,
        output dirty_cen, dirty_gwen, dirty_idx, dirty_din, dirty_wen
    );

endinterface

// File: rtl/ct_l2cache_dirty_ctrl.sv
// Arbitrates between the zeroing sweep and pipeline read/way-write requests and
// drives the single-port dirty array combinationally; read data returns one cycle later.
module ct_l2cache_dirty_ctrl
    import ct_l2cache_dirty_pkg::*;
#(
    parameter int TAG_INDEX_WIDTH = L2C_TAG_INDEX_WIDTH
)(
    input logic                     forever_cpuclk,
    input logic                     cpurst,
    ct_l2cache_dirty_ctrl_if.slave  bus
);

    localparam logic [TAG_INDEX_WIDTH-1:0] CNT_LAST = '1;

    l2c_dirty_state_e             state_q, state_d;
    logic [TAG_INDEX_WIDTH-1:0]   cnt_q, cnt_d;
    logic                         rsp_vld_q, rsp_vld_d;

    // Per-bit write enable is active-low: only the nine bits of the target way go low.
    function automatic logic [L2C_DIRTY_WIDTH-1:0] way_wen(input logic [3:0] way);
        logic [L2C_DIRTY_WIDTH-1:0] m;
        m = '1;
        for (int w = 0; w < L2C_DIRTY_WAYS; w++) begin
            if (way == 4'(w)) begin
                m[w*L2C_DIRTY_WAY_BITS +: L2C_DIRTY_WAY_BITS] = '0;
            end
        end
        return m;
    endfunction

    always_ff @(posedge forever_cpuclk or posedge cpurst) begin
        if (cpurst) begin
            state_q   <= L2C_DIRTY_INIT;
            cnt_q     <= '0;
            rsp_vld_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rsp_vld_q <= rsp_vld_d;
        end
    end

    // Reset holds the array quiet even though the state register already sits in INIT.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        rsp_vld_d      = 1'b0;
        bus.req_rdy    = 1'b0;
        bus.init_busy  = 1'b1;
        bus.dirty_cen  = 1'b1;
        bus.dirty_gwen = 1'b1;
        bus.dirty_wen  = '1;
        bus.dirty_din  = '0;
        bus.dirty_idx  = bus.req_idx;

        if (!cpurst) begin
            unique case (state_q)
                L2C_DIRTY_INIT: begin
                    bus.dirty_cen  = 1'b0;
                    bus.dirty_gwen = 1'b0;
                    bus.dirty_wen  = '0;
                    bus.dirty_idx  = cnt_q;
                    cnt_d          = cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        state_d = L2C_DIRTY_IDLE;
                    end
                end
                L2C_DIRTY_IDLE: begin
                    bus.init_busy = 1'b0;
                    bus.req_rdy   = !bus.init_req;
                    if (bus.init_req) begin
                        state_d = L2C_DIRTY_INIT;
                        cnt_d   = '0;
                    end else if (bus.req_vld) begin
                        bus.dirty_cen = 1'b0;
                        rsp_vld_d     = !bus.req_wr;
                        if (bus.req_wr) begin
                            bus.dirty_gwen = 1'b0;
                            bus.dirty_din  = {L2C_DIRTY_WAYS{bus.req_data}};
                            bus.dirty_wen  = way_wen(bus.req_way);
                        end
                    end
                end
                default: begin
                    state_d = L2C_DIRTY_INIT;
                end
            endcase
        end
    end

    assign bus.rsp_vld  = rsp_vld_q;
    assign bus.rsp_data = rsp_vld_q ? bus.dirty_dout : '0;

endmodule

// File: tb/tb_ct_l2cache_dirty_ctrl.sv
// Drives the dirty controller beside a behavioural SRAM and checks every cycle
// against a way-level reference of the array contents and the sweep position.
module tb_ct_l2cache_dirty_ctrl;
    import ct_l2cache_dirty_pkg::*;

    localparam int IW    = 7;
    localparam int DEPTH = 1 << IW;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    ct_l2cache_dirty_ctrl_if #(.TAG_INDEX_WIDTH(IW)) bus();

    ct_l2cache_dirty_ctrl #(.TAG_INDEX_WIDTH(IW)) dut (
        .forever_cpuclk (clk),
        .cpurst         (rst),
        .bus            (bus)
    );

    // Single-port array: bit-masked write, registered read data.
    logic [143:0] sram [DEPTH];
    always @(posedge clk) begin
        if (!bus.dirty_cen) begin
            if (!bus.dirty_gwen)
                sram[bus.dirty_idx] <= (sram[bus.dirty_idx] & bus.dirty_wen) | (bus.dirty_din & ~bus.dirty_wen);
            else
                bus.dirty_dout <= sram[bus.dirty_idx];
        end
    end

    int           assertCount = 0;
    int           failCount   = 0;
    int           refWay [DEPTH][16];
    int           sweepIdx    = 0;
    logic [143:0] expQ [$];

    function automatic logic [143:0] packRow(input logic [IW-1:0] row);
        logic [143:0] r;
        r = '0;
        for (int w = 0; w < 16; w++) r[w*9 +: 9] = 9'(refWay[row][w]);
        return r;
    endfunction

    task automatic zeroRef();
        for (int i = 0; i < DEPTH; i++)
            for (int w = 0; w < 16; w++) refWay[i][w] = 0;
    endtask

    task automatic checkOutput(input string tag, input logic [143:0] obs, input logic [143:0] exp);
        assertCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic checkResponse();
        logic [143:0] e;
        if (expQ.size() > 0) begin
            e = expQ.pop_front();
            checkOutput("rsp_vld", 144'(bus.rsp_vld), 144'(1));
            checkOutput("rsp_data", bus.rsp_data, e);
        end else begin
            checkOutput("rsp_vld_idle", 144'(bus.rsp_vld), 144'(0));
            checkOutput("rsp_data_idle", bus.rsp_data, '0);
        end
    endtask

    task automatic checkNoAccess(input logic [IW-1:0] idx);
        checkOutput("cen_none", 144'(bus.dirty_cen), 144'(1));
        checkOutput("gwen_none", 144'(bus.dirty_gwen), 144'(1));
        checkOutput("wen_none", bus.dirty_wen, {144{1'b1}});
        checkOutput("din_none", bus.dirty_din, '0);
        checkOutput("idx_none", 144'(bus.dirty_idx), 144'(idx));
    endtask

    // One clock cycle: check the response due now, drive inputs, check array drive, advance.
    task automatic applyStimulus(input logic vld, input logic wr, input logic [IW-1:0] idx,
                                 input logic [3:0] way, input logic [8:0] data, input logic init);
        logic [143:0] m;
        checkResponse();
        bus.req_vld  = vld;
        bus.req_wr   = wr;
        bus.req_idx  = idx;
        bus.req_way  = way;
        bus.req_data = data;
        bus.init_req = init;
        #1;
        if (sweepIdx >= 0) begin
            checkOutput("sweep_cen", 144'(bus.dirty_cen), 144'(0));
            checkOutput("sweep_gwen", 144'(bus.dirty_gwen), 144'(0));
            checkOutput("sweep_wen", bus.dirty_wen, '0);
            checkOutput("sweep_din", bus.dirty_din, '0);
            checkOutput("sweep_idx", 144'(bus.dirty_idx), 144'(sweepIdx));
            checkOutput("sweep_rdy", 144'(bus.req_rdy), 144'(0));
            checkOutput("sweep_busy", 144'(bus.init_busy), 144'(1));
            sweepIdx++;
            if (sweepIdx == DEPTH) sweepIdx = -1;
        end else begin
            checkOutput("idle_busy", 144'(bus.init_busy), 144'(0));
            checkOutput("idle_rdy", 144'(bus.req_rdy), 144'(!init));
            if (init) begin
                checkNoAccess(idx);
                sweepIdx = 0;
                zeroRef();
            end else if (vld && !wr) begin
                checkOutput("rd_cen", 144'(bus.dirty_cen), 144'(0));
                checkOutput("rd_gwen", 144'(bus.dirty_gwen), 144'(1));
                checkOutput("rd_wen", bus.dirty_wen, {144{1'b1}});
                checkOutput("rd_idx", 144'(bus.dirty_idx), 144'(idx));
                expQ.push_back(packRow(idx));
            end else if (vld && wr) begin
                m = 144'h1FF;
                m = ~(m << (9 * int'(way)));
                checkOutput("wr_cen", 144'(bus.dirty_cen), 144'(0));
                checkOutput("wr_gwen", 144'(bus.dirty_gwen), 144'(0));
                checkOutput("wr_idx", 144'(bus.dirty_idx), 144'(idx));
                checkOutput("wr_din", bus.dirty_din, {16{data}});
                checkOutput("wr_wen", bus.dirty_wen, m);
                refWay[idx][way] = int'(data);
            end else begin
                checkNoAccess(idx);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        rst = 1'b1;
        expQ.delete();
        for (int c = 0; c < 2; c++) begin
            #1;
            checkOutput("rst_cen", 144'(bus.dirty_cen), 144'(1));
            checkOutput("rst_gwen", 144'(bus.dirty_gwen), 144'(1));
            checkOutput("rst_wen", bus.dirty_wen, {144{1'b1}});
            checkOutput("rst_rdy", 144'(bus.req_rdy), 144'(0));
            checkOutput("rst_busy", 144'(bus.init_busy), 144'(1));
            checkOutput("rst_rsp_vld", 144'(bus.rsp_vld), 144'(0));
            checkOutput("rst_rsp_data", bus.rsp_data, '0);
            @(posedge clk);
        end
        #1;
        rst = 1'b0;
        sweepIdx = 0;
        zeroRef();
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, 1'b0, 7'($urandom_range(0, DEPTH-1)), 4'd0, 9'd0, 1'b0);
    endtask

    task automatic noiseCycle();
        applyStimulus(1'($urandom), 1'($urandom), 7'($urandom_range(0, DEPTH-1)),
                      4'($urandom), 9'($urandom), 1'($urandom));
    endtask

    initial begin
        bus.req_vld  = 1'b0;
        bus.req_wr   = 1'b0;
        bus.req_idx  = '0;
        bus.req_way  = '0;
        bus.req_data = '0;
        bus.init_req = 1'b0;
        for (int i = 0; i < DEPTH; i++)
            sram[i] = {$urandom, $urandom, $urandom, $urandom, $urandom};
        zeroRef();

        doReset();
        // Requests and init pulses during the sweep must be ignored.
        while (sweepIdx >= 0) noiseCycle();
        idleCycle();

        applyStimulus(1'b1, 1'b1, 7'd5, 4'd3, 9'h1A5, 1'b0);
        applyStimulus(1'b1, 1'b0, 7'd5, 4'd0, 9'h000, 1'b0);
        idleCycle();

        applyStimulus(1'b1, 1'b1, 7'd9, 4'd0, 9'h0C3, 1'b0);
        applyStimulus(1'b1, 1'b1, 7'd9, 4'd15, 9'h15A, 1'b0);
        applyStimulus(1'b1, 1'b0, 7'd9, 4'd0, 9'h000, 1'b0);
        idleCycle();

        // Init coincident with a read: the read is dropped and the sweep runs.
        applyStimulus(1'b1, 1'b0, 7'd5, 4'd0, 9'h000, 1'b1);
        while (sweepIdx >= 0) idleCycle();
        for (int i = 0; i < 4; i++)
            applyStimulus(1'b1, 1'b0, (i < 2) ? 7'(5 + 4*i) : 7'($urandom_range(0, DEPTH-1)), 4'd0, 9'd0, 1'b0);
        idleCycle();

        // Reset partway through a sweep restarts it from index 0.
        applyStimulus(1'b0, 1'b0, 7'd0, 4'd0, 9'd0, 1'b1);
        while (sweepIdx != 40) noiseCycle();
        doReset();
        while (sweepIdx >= 0) noiseCycle();

        // Reset while a read response is pending clears it immediately.
        applyStimulus(1'b1, 1'b0, 7'd3, 4'd0, 9'd0, 1'b0);
        doReset();
        while (sweepIdx >= 0) idleCycle();

        // Read followed by init: response carries the pre-sweep contents.
        applyStimulus(1'b1, 1'b1, 7'd20, 4'd7, 9'h0F0, 1'b0);
        applyStimulus(1'b1, 1'b0, 7'd20, 4'd0, 9'd0, 1'b0);
        applyStimulus(1'b0, 1'b0, 7'd0, 4'd0, 9'd0, 1'b1);
        while (sweepIdx >= 0) noiseCycle();

        for (int i = 0; i < 400; i++) begin
            applyStimulus(($urandom % 4) != 0, 1'($urandom), 7'($urandom_range(0, DEPTH-1)),
                          4'($urandom), 9'($urandom), ($urandom % 150) == 0);
        end
        while (sweepIdx >= 0) idleCycle();
        idleCycle();
        idleCycle();

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/ct_l2cache_dirty_ctrl.md
# ct_l2cache_dirty_ctrl

Access controller directly upstream of the 16-way L2 dirty array (single-port 144-bit SRAM, 16 ways × 9-bit state field per index). It arbitrates between a post-reset/on-demand zeroing sweep and pipeline read/way-write requests, and drives the array's active-low enables and per-bit write mask. It returns read data one cycle after acceptance. The parent instantiates this block beside the array and wires the `dirty_*` ports point-to-point.

## Interface
- `TAG_INDEX_WIDTH`, default `L2C_TAG_INDEX_WIDTH` (9 for 1M): array index width; array depth is 2^TAG_INDEX_WIDTH.
- `forever_cpuclk`  in  1  clock, same as `dirty_clk`.
- `cpurst`  in  1  reset, asynchronous, active-high.
- `req_vld`  in  1  request valid.
- `req_rdy`  out  1  request accepted when `req_vld & req_rdy`.
- `req_wr`  in  1  1 = way write, 0 = read of all 16 ways.
- `req_idx`  in  TAG_INDEX_WIDTH  array index.
- `req_way`  in  4  target way (writes only).
- `req_data`  in  9  new state field for `req_way` (writes only).
- `init_req`  in  1  pulse: re-zero the whole array.
- `init_busy`  out  1  sweep in progress.
- `rsp_vld`  out  1  read data valid (one-cycle pulse).
- `rsp_data`  out  144  read data, way w at bits [9w+8:9w].
- `dirty_cen`, `dirty_gwen`  out  1  array chip/global-write enable, active-low.
- `dirty_idx`  out  TAG_INDEX_WIDTH  array address.
- `dirty_din`, `dirty_wen`  out  144  write data / per-bit write enable (bit low = write).
- `dirty_dout`  in  144  array output, valid the cycle after a read.

## Operation
- States: INIT, IDLE. Async reset → INIT, sweep counter = 0, `rsp_vld` = 0.
- While `cpurst` high: `dirty_cen`=1, `dirty_gwen`=1, `dirty_wen`=all ones, `req_rdy`=0, `init_busy`=1, `rsp_data`=0.
- INIT, each cycle: `dirty_cen`=0, `dirty_gwen`=0, `dirty_wen`=0, `dirty_din`=0, `dirty_idx`=counter; counter++. After writing index 2^TAG_INDEX_WIDTH−1, go to IDLE next cycle, counter wraps to 0. `req_rdy`=0, `init_busy`=1. `init_req` in INIT is ignored (no restart).
- IDLE: `init_busy`=0; `req_rdy` = !`init_req`. `init_req`=1 → INIT next cycle, counter=0; it wins over a same-cycle `req_vld` (that request is not accepted).
- Accepted read: `dirty_cen`=0, `dirty_gwen`=1, `dirty_wen`=all ones, `dirty_idx`=`req_idx`.
- Accepted write: `dirty_cen`=0, `dirty_gwen`=0, `dirty_idx`=`req_idx`, `dirty_din`={16{`req_data`}}, `dirty_wen` low only on bits [9·way+8 : 9·way].
- No access: `dirty_cen`=1, `dirty_gwen`=1, `dirty_wen`=all ones, `dirty_din`=0, `dirty_idx`=`req_idx`.
- Array drive is combinational from state/counter/accepted request; there is no input flop.

## Timing
- Throughput: one request per cycle in IDLE; no back-pressure on responses.
- Read accepted cycle N → `rsp_vld`=1 in N+1 with `rsp_data`=`dirty_dout`; `rsp_data`=0 whenever `rsp_vld`=0.
- Write at N, read of same index at N+1: response (N+2) reflects the write (array ordering).
- Read at N followed by `init_req` at N+1: response still delivered at N+1; the sweep starts N+2.
- Sweep length exactly 2^TAG_INDEX_WIDTH cycles. `req_rdy` rises the cycle after the last index is written.
- Reset asserted mid-sweep or mid-read: pending `rsp_vld` is cleared immediately and the sweep restarts from index 0 after deassertion.

## Structure
- Shared package `ct_l2cache_dirty_pkg`: `L2C_DIRTY_WAYS`=16, `L2C_DIRTY_WAY_BITS`=9, `L2C_DIRTY_WIDTH`=144, state encoding (INIT/IDLE, 1 bit).
- Way-mask decode is a local function. No sub-module: this block is a flat controller, and the array is instantiated by the parent.

## Test plan
- Reset release with TAG_INDEX_WIDTH=7 → exactly 128 write cycles, idx 0..127, din=0, wen=0; `req_rdy` high on cycle 129.
- Write idx 5, way 3, data 9'h1A5, then read idx 5 → `rsp_vld` one cycle later, bits [35:27]=9'h1A5, all other bits 0.
- Back-to-back writes to ways 0 and 15 of idx 9, then read → both fields present; `dirty_wen` masks are 0x…1FF and 0x1FF<<135 (inverted).
- `init_req` coincident with `req_vld` in IDLE → request not accepted, `init_busy`=1 next cycle; a later read of any index returns 0.
- `cpurst` pulse at sweep index 40 → array idle during reset; sweep restarts at idx 0 and runs the full length.
- Read accepted, then `init_req` next cycle → response delivered with pre-sweep data; no response is generated during INIT.
